// File: rtl/traffic_phase_ctrl.sv
// N-phase signalised-intersection controller: green/yellow/all-red cycle with sticky demand and
// round-robin service. Define TRAFFIC_PREEMPT_EN to enable emergency preemption.
module traffic_phase_ctrl #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned MIN_GREEN  = 10,
  parameter int unsigned MAX_GREEN  = 40,
  parameter int unsigned YELLOW     = 4,
  parameter int unsigned ALL_RED    = 3,
  parameter int unsigned TIMER_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         req,
  input  logic                          preempt,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] cur_phase
);

  localparam int unsigned PW = $clog2(NUM_PHASES);
  localparam logic [TIMER_W-1:0] MinLast = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MaxLast = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YelLast = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] ArLast  = TIMER_W'(ALL_RED - 1);

  typedef enum logic [1:0] {StGreen = 2'd0, StYellow = 2'd1, StAllRed = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [PW-1:0]           target_q, target_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [NUM_PHASES-1:0]   pending_q, pending_d;
  logic [NUM_PHASES-1:0]   req_s1_q, req_sync_q;
  logic [NUM_PHASES-1:0]   enter_mask;
  logic                    enter;
  logic                    pre_active;
  logic [PW-1:0]           pre_phase;
  logic                    any_pend;
  logic [PW-1:0]           next_pend;
  logic [PW-1:0]           succ_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1_q   <= '0;
      req_sync_q <= '0;
    end else begin
      req_s1_q   <= req;
      req_sync_q <= req_s1_q;
    end
  end

`ifdef TRAFFIC_PREEMPT_EN
  logic          pre_s1_q, pre_sync_q;
  logic [PW-1:0] pp_s1_q, pp_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_s1_q   <= 1'b0;
      pre_sync_q <= 1'b0;
      pp_s1_q    <= '0;
      pp_sync_q  <= '0;
    end else begin
      pre_s1_q   <= preempt;
      pre_sync_q <= pre_s1_q;
      pp_s1_q    <= preempt_phase;
      pp_sync_q  <= pp_s1_q;
    end
  end

  assign pre_active = pre_sync_q;
  assign pre_phase  = pp_sync_q;
`else
  logic unused_preempt;
  assign unused_preempt = ^{preempt, preempt_phase};
  assign pre_active     = 1'b0;
  assign pre_phase      = '0;
`endif

  // Nearest pending phase searching cyclically from phase_q+1; smallest distance wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_pend  = 1'b0;
    next_pend = '0;
    for (int unsigned k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = 32'(phase_q) + k;
      if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
      if (pending_q[idx[PW-1:0]]) begin
        any_pend  = 1'b1;
        next_pend = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt = 32'(phase_q) + 1;
    if (nxt >= NUM_PHASES) nxt = 0;
    succ_phase = nxt[PW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    target_d = target_q;
    enter    = 1'b0;
    unique case (state_q)
      StGreen: begin
        if (pre_active && (pre_phase != phase_q)) begin
          state_d  = StYellow;
          target_d = pre_phase;
        end else if (!pre_active && (timer_q >= MinLast) && (any_pend || (timer_q >= MaxLast)))
        begin
          state_d  = StYellow;
          target_d = any_pend ? next_pend : succ_phase;
        end
      end
      StYellow: begin
        if (pre_active) target_d = pre_phase;
        if (timer_q >= YelLast) state_d = StAllRed;
      end
      StAllRed: begin
        if (pre_active) target_d = pre_phase;
        if (timer_q >= ArLast) begin
          state_d = StGreen;
          phase_d = target_d;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d  = StAllRed;
        target_d = '0;
        phase_d  = '0;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (&timer_q) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // The entering phase is cleared even if its request is still asserted this cycle.
  always_comb begin
    enter_mask = '0;
    if (enter) enter_mask[phase_d] = 1'b1;
    pending_d = (pending_q | req_sync_q) & ~enter_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StAllRed;
      phase_q   <= '0;
      target_q  <= '0;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    if (state_q == StGreen)  green[phase_q]  = 1'b1;
    if (state_q == StYellow) yellow[phase_q] = 1'b1;
  end

  assign red       = ~(green | yellow);
  assign cur_phase = (state_q == StAllRed) ? target_q : phase_q;

  lamp_onehot_chk: assert property (@(posedge clk) disable iff (rst)
      $onehot0(green) && $onehot0(yellow))
    else $fatal(1, "traffic_phase_ctrl: more than one lamp lit");

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: expected lamp segments (lamps, cur_phase, length)
// are queued by the stimulus and checked by a monitor as each segment ends.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       preempt = 1'b0;
  logic [1:0] preempt_phase = '0;
  logic [3:0] green, yellow, red;
  logic [1:0] cur_phase;

  traffic_phase_ctrl #(
    .NUM_PHASES(4), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW(2), .ALL_RED(2), .TIMER_W(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .preempt(preempt), .preempt_phase(preempt_phase),
    .green(green), .yellow(yellow), .red(red), .cur_phase(cur_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] cp;
    int         len;  // negative: length not checked (segment cut short by the next reset)
  } seg_t;

  seg_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   sb_en = 1'b0;

  logic [3:0] run_g, run_y, run_r;
  logic [1:0] run_cp;
  int         run_len;
  bit         run_v = 1'b0;

  task automatic push(input logic [3:0] g, input logic [3:0] y, input logic [1:0] cp,
                      input int len);
    seg_t s;
    s.g = g; s.y = y; s.cp = cp; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic close_run();
    seg_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL segment unexpected: got g=%b y=%b cp=%0d len=%0d, required none",
               run_g, run_y, run_cp, run_len);
    end else begin
      e = exp_q.pop_front();
      if (run_g != e.g || run_y != e.y || run_cp != e.cp || run_r != ~(e.g | e.y) ||
          (e.len >= 0 && run_len != e.len)) begin
        n_fail++;
        $display("FAIL segment: got g=%b y=%b r=%b cp=%0d len=%0d, required g=%b y=%b cp=%0d len=%0d",
                 run_g, run_y, run_r, run_cp, run_len, e.g, e.y, e.cp, e.len);
      end
    end
  endtask

  // Monitor: a segment ends when lamps/cur_phase change or reset is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !sb_en) begin
        if (run_v && sb_en) close_run();
        run_v = 1'b0;
      end else if (run_v && {green, yellow, cur_phase} == {run_g, run_y, run_cp}) begin
        run_len++;
      end else begin
        if (run_v) close_run();
        run_v = 1'b1;
        run_g = green; run_y = yellow; run_r = red; run_cp = cur_phase;
        run_len = 1;
      end
    end
  end

  task automatic begin_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req = '0; preempt = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() > 1 && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL %s drain: %0d segments outstanding, required at most 1", name, exp_q.size());
    end
  endtask

  // Idle cycle with no demand: each phase in turn served for MAX_GREEN.
  task automatic push_idle_start();
    push(4'b0000, 4'b0000, 2'd0, 2);
    push(4'b0001, 4'b0000, 2'd0, 8);
    push(4'b0000, 4'b0001, 2'd0, 2);
    push(4'b0000, 4'b0000, 2'd1, 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         wt[4];
    logic [3:0] rq;
    sb_en = 1'b1;

    // Reset release with no demand
    repeat (2) @(posedge clk);
    push_idle_start();
    push(4'b0010, 4'b0000, 2'd1, -1);
    release_rst();
    wait_drain("idle");

    // One-cycle pulse on phase 2 during green 0 at timer 0: green cut to MIN_GREEN
    begin_reset();
    push(4'b0000, 4'b0000, 2'd0, 2);
    push(4'b0001, 4'b0000, 2'd0, 4);
    push(4'b0000, 4'b0001, 2'd0, 2);
    push(4'b0000, 4'b0000, 2'd2, 2);
    push(4'b0100, 4'b0000, 2'd2, -1);
    release_rst();
    repeat (2) @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk);
    #1 req = 4'b0000;
    wait_drain("pulse");

    // Held demand on phases 1 and 3: served 1,3,1,... and phase 2 never green
    begin_reset();
    push(4'b0000, 4'b0000, 2'd0, 2);
    push(4'b0001, 4'b0000, 2'd0, 4);
    push(4'b0000, 4'b0001, 2'd0, 2);
    push(4'b0000, 4'b0000, 2'd1, 2);
    push(4'b0010, 4'b0000, 2'd1, 4);
    push(4'b0000, 4'b0010, 2'd1, 2);
    push(4'b0000, 4'b0000, 2'd3, 2);
    push(4'b1000, 4'b0000, 2'd3, 4);
    push(4'b0000, 4'b1000, 2'd3, 2);
    push(4'b0000, 4'b0000, 2'd1, 2);
    push(4'b0010, 4'b0000, 2'd1, -1);
    release_rst();
    repeat (2) @(posedge clk);
    #1 req = 4'b1010;
    wait_drain("roundrobin");

    // Asynchronous reset in the first cycle of yellow on phase 1
    begin_reset();
    push_idle_start();
    push(4'b0010, 4'b0000, 2'd1, 8);
    push(4'b0000, 4'b0010, 2'd1, 1);
    release_rst();
    begin
      int i;
      i = 0;
      while (yellow != 4'b0010 && i < 100) begin
        @(negedge clk);
        i++;
      end
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (green != 4'b0000 || yellow != 4'b0000 || red != 4'b1111) begin
      n_fail++;
      $display("FAIL async reset lamps: got g=%b y=%b r=%b, required g=0000 y=0000 r=1111",
               green, yellow, red);
    end
    push_idle_start();
    push(4'b0010, 4'b0000, 2'd1, -1);
    release_rst();
    wait_drain("after_reset");

`ifdef TRAFFIC_PREEMPT_EN
    // Preempt to phase 2 at timer 1 of green 0, then hold beyond MAX_GREEN
    begin_reset();
    push(4'b0000, 4'b0000, 2'd0, 2);
    push(4'b0001, 4'b0000, 2'd0, 4);
    push(4'b0000, 4'b0001, 2'd0, 2);
    push(4'b0000, 4'b0000, 2'd2, 2);
    push(4'b0100, 4'b0000, 2'd2, -1);
    release_rst();
    repeat (3) @(posedge clk);
    #1;
    preempt = 1'b1;
    preempt_phase = 2'd2;
    wait_drain("preempt");
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if (green != 4'b0100) begin
      n_fail++;
      $display("FAIL preempt hold: got green=%b, required 0100", green);
    end
`endif

    begin_reset();
    @(negedge clk);
    sb_en = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover segments: got %0d, required 0", exp_q.size());
    end

    // Random held demand; each phase must go green within 3*(MAX+YELLOW+ALL_RED)+3 cycles
    rq = '0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    release_rst();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (green[i]) begin
          if (wt[i] > 0) begin
            n_vec++;
            if (wt[i] > 39) begin
              n_fail++;
              $display("FAIL service phase %0d: got wait %0d, required <= 39", i, wt[i]);
            end
          end
          wt[i] = 0;
          rq[i] = 1'b0;
        end else if (rq[i]) begin
          wt[i]++;
          if (wt[i] == 60) begin
            n_vec++;
            n_fail++;
            $display("FAIL starvation phase %0d: got wait 60, required <= 39", i);
          end
        end else if ($urandom_range(7) == 0) begin
          rq[i] = 1'b1;
        end
      end
      req = rq;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
